// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - multi-channel push-button synchroniser, debouncer and long-press detector
//
// Purpose: brings raw, bouncing front-panel buttons into the clock domain,
// filters each channel with its own stability counter and flags long presses.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   button_raw   in   [NUM_BUTTONS] raw button levels, 1 = pressed
//   button_clean out  [NUM_BUTTONS] debounced level per channel
//   button_held  out  [NUM_BUTTONS] long-press level per channel
//   any_pressed  out  registered OR of button_clean
module button_debounce #(
  parameter int NUM_BUTTONS   = 5,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES   = 50_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_raw,
  output logic [NUM_BUTTONS-1:0] button_clean,
  output logic [NUM_BUTTONS-1:0] button_held,
  output logic                   any_pressed
);

  localparam int MAX_TERM  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_WIDTH = $clog2(MAX_TERM + 1);

  localparam logic [CNT_WIDTH-1:0] DCNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HCNT_LAST = CNT_WIDTH'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("button_debounce: STABLE_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("button_debounce: HOLD_CYCLES must be >= 1");
  end

  // Next-state clean vector, gathered so any_pressed moves on the same edge.
  logic [NUM_BUTTONS-1:0] clean_next;
  logic                   any_pressed_q;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    logic                 sync1_q;
    logic                 sync2_q;
    logic                 clean_q, clean_d;
    logic                 held_q,  held_d;
    logic [CNT_WIDTH-1:0] dcnt_q,  dcnt_d;
    logic [CNT_WIDTH-1:0] hcnt_q,  hcnt_d;

    always_comb begin
      clean_d = clean_q;
      dcnt_d  = '0;
      if (sync2_q != clean_q) begin
        if (dcnt_q == DCNT_LAST) begin
          clean_d = sync2_q;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
    end

    // Counting runs off the registered clean level so held lands exactly
    // HOLD_CYCLES edges after clean rose; the next-state term clears hold
    // state on the very edge clean falls.
    always_comb begin
      hcnt_d = hcnt_q;
      held_d = 1'b0;
      if (!clean_q || !clean_d) begin
        hcnt_d = '0;
      end else begin
        if (hcnt_q < HCNT_LAST) begin
          hcnt_d = hcnt_q + CNT_ONE;
        end
        held_d = (hcnt_d == HCNT_LAST);
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        clean_q <= 1'b0;
        held_q  <= 1'b0;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
      end else begin
        sync1_q <= button_raw[g];
        sync2_q <= sync1_q;
        clean_q <= clean_d;
        held_q  <= held_d;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
      end
    end

    assign clean_next[g]   = clean_d;
    assign button_clean[g] = clean_q;
    assign button_held[g]  = held_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      any_pressed_q <= 1'b0;
    end else begin
      any_pressed_q <= |clean_next;
    end
  end

  assign any_pressed = any_pressed_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - self-checking bench for button_debounce
//
// Purpose: drives per-cycle segments from a table and hand-written reset
// sequences; expected outputs are queued when stimulus is applied and
// compared after the following rising edge.
//
// Ports: none (top-level bench).
module tb_button_debounce;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] button_raw;
  logic [1:0] button_clean;
  logic [1:0] button_held;
  logic       any_pressed;

  button_debounce #(
    .NUM_BUTTONS  (2),
    .STABLE_CYCLES(4),
    .HOLD_CYCLES  (10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .button_raw  (button_raw),
    .button_clean(button_clean),
    .button_held (button_held),
    .any_pressed (any_pressed)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         n;
    logic [1:0] raw;
    logic [1:0] clean;
    logic [1:0] held;
    logic       any;
    string      name;
  } seg_t;

  typedef struct {
    logic [4:0] exp;
    string      name;
    int         cyc;
  } exp_t;

  seg_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input int n, input logic [1:0] raw, input logic [1:0] clean,
                     input logic [1:0] held, input logic any, input string name);
    seg_t s;
    s.n = n; s.raw = raw; s.clean = clean; s.held = held; s.any = any; s.name = name;
    tbl.push_back(s);
  endtask

  task automatic check_now(input string name, input int cyc, input logic [4:0] exp);
    logic [4:0] act;
    act = {button_clean, button_held, any_pressed};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d clean/held/any got %b want %b", name, cyc, act, exp);
    end
  endtask

  // Called at a negedge: applies raw for n cycles, checking after each rising edge.
  task automatic run_seg(input seg_t s);
    exp_t e;
    for (int i = 0; i < s.n; i++) begin
      button_raw = s.raw;
      e.exp  = {s.clean, s.held, s.any};
      e.name = s.name;
      e.cyc  = i;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      check_now(e.name, e.cyc, e.exp);
      @(negedge clock);
    end
  endtask

  initial begin
    reset      = 1'b1;
    button_raw = 2'b00;

    // clean press on ch0, hold, release while held
    add(5,  2'b01, 2'b00, 2'b00, 1'b0, "press_wait");
    add(10, 2'b01, 2'b01, 2'b00, 1'b1, "press_clean");
    add(3,  2'b01, 2'b01, 2'b01, 1'b1, "press_held");
    add(5,  2'b00, 2'b01, 2'b01, 1'b1, "rel0_wait");
    add(3,  2'b00, 2'b00, 2'b00, 1'b0, "rel0_done");
    // bounce 1,1,1,0,1,1,1,0 then steady 1
    add(3,  2'b01, 2'b00, 2'b00, 1'b0, "bounce_a");
    add(1,  2'b00, 2'b00, 2'b00, 1'b0, "bounce_b");
    add(3,  2'b01, 2'b00, 2'b00, 1'b0, "bounce_c");
    add(1,  2'b00, 2'b00, 2'b00, 1'b0, "bounce_d");
    add(5,  2'b01, 2'b00, 2'b00, 1'b0, "bounce_settle");
    add(3,  2'b01, 2'b01, 2'b00, 1'b1, "bounce_clean");
    add(5,  2'b00, 2'b01, 2'b00, 1'b1, "bounce_rel_wait");
    add(2,  2'b00, 2'b00, 2'b00, 1'b0, "bounce_rel_done");
    // long press on ch1, release while held
    add(5,  2'b10, 2'b00, 2'b00, 1'b0, "long_wait");
    add(10, 2'b10, 2'b10, 2'b00, 1'b1, "long_clean");
    add(41, 2'b10, 2'b10, 2'b10, 1'b1, "long_held");
    add(5,  2'b00, 2'b10, 2'b10, 1'b1, "rel1_wait");
    add(2,  2'b00, 2'b00, 2'b00, 1'b0, "rel1_done");
    // simultaneous channels, release only ch0
    add(5,  2'b11, 2'b00, 2'b00, 1'b0, "sim_wait");
    add(3,  2'b11, 2'b11, 2'b00, 1'b1, "sim_clean");
    add(5,  2'b10, 2'b11, 2'b00, 1'b1, "sim_rel0_wait");
    add(2,  2'b10, 2'b10, 2'b00, 1'b1, "sim_rel0_done");
    add(1,  2'b10, 2'b10, 2'b10, 1'b1, "sim_held1");
    add(5,  2'b00, 2'b10, 2'b10, 1'b1, "sim_rel1_wait");
    add(2,  2'b00, 2'b00, 2'b00, 1'b0, "sim_rel1_done");

    @(negedge clock);
    check_now("reset_state", 0, 5'b0);
    button_raw = 2'b11;
    @(negedge clock);
    check_now("reset_raw_high", 0, 5'b0);
    button_raw = 2'b00;
    @(negedge clock);
    reset = 1'b0;

    foreach (tbl[i]) run_seg(tbl[i]);

    // async reset while ch0 is held
    begin
      seg_t s;
      s.n = 5;  s.raw = 2'b01; s.clean = 2'b00; s.held = 2'b00; s.any = 1'b0; s.name = "pre_rst_wait";
      run_seg(s);
      s.n = 10; s.clean = 2'b01; s.any = 1'b1; s.name = "pre_rst_clean";
      run_seg(s);
      s.n = 2;  s.held = 2'b01; s.name = "pre_rst_held";
      run_seg(s);
      #2 reset = 1'b1;
      #1 check_now("async_reset_immediate", 0, 5'b0);
      @(posedge clock);
      #1 check_now("reset_held_edge", 0, 5'b0);
      @(negedge clock);
      reset = 1'b0;
      s.n = 5;  s.clean = 2'b00; s.held = 2'b00; s.any = 1'b0; s.name = "post_rst_wait";
      run_seg(s);
      s.n = 10; s.clean = 2'b01; s.any = 1'b1; s.name = "post_rst_clean";
      run_seg(s);
      s.n = 2;  s.held = 2'b01; s.name = "post_rst_held";
      run_seg(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
